// File: rtl/mips_mmio_timer.sv
// mips_mmio_timer: memory-mapped prescaled 32-bit timer with compare/match/irq; TIMER_CAPTURE_EN adds input capture.
module mips_mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        hit,
    output logic        irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic        capture_in
`endif
);
    logic [2:0]            ctrl;
    logic [31:0]           count, compare, capture;
    logic                  match, cap;
    logic [PRESCALE_W-1:0] prescale, pcnt;
    logic [2:0]            sel;
    logic                  we, wr_ctrl, wr_count, wr_cmp, wr_stat, wr_pre;
    logic                  tick, set_match, cap_evt;
    logic                  unused_bits;

    assign hit         = memaddr[31:5] == BASE_ADDR[31:5];
    assign sel         = memaddr[4:2];
    assign we          = memwrite & hit;
    assign wr_ctrl     = we && sel == 3'd0;
    assign wr_count    = we && sel == 3'd1;
    assign wr_cmp      = we && sel == 3'd2;
    assign wr_stat     = we && sel == 3'd3;
    assign wr_pre      = we && sel == 3'd4;
    assign tick        = ctrl[0] && pcnt == prescale;
    // a CPU write to COUNT suppresses both the increment and the match check
    assign set_match   = tick && !wr_count && count == compare;
    assign unused_bits = &{1'b0, memaddr[1:0]};

`ifdef TIMER_CAPTURE_EN
    logic [2:0] sync;
    always_ff @(posedge clk)
        sync <= reset ? 3'b0 : {sync[1:0], capture_in};
    assign cap_evt = sync[1] & ~sync[2];
`else
    assign cap_evt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            count    <= '0;
            compare  <= 32'hFFFF_FFFF;
            match    <= 1'b0;
            cap      <= 1'b0;
            prescale <= '0;
            pcnt     <= '0;
            capture  <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= memwritedata[2:0];
            if (wr_count) count <= memwritedata;
            else if (tick) count <= (set_match && ctrl[1]) ? 32'h0 : count + 32'h1;
            if (wr_cmp) compare <= memwritedata;
            if (wr_pre) prescale <= memwritedata[PRESCALE_W-1:0];
            pcnt    <= (wr_pre || tick) ? '0 : ctrl[0] ? pcnt + 1'b1 : pcnt;
            match   <= set_match | (match & ~(wr_stat & memwritedata[0]));
            cap     <= cap_evt | (cap & ~(wr_stat & memwritedata[1]));
            if (cap_evt) capture <= count;
            irq     <= (match | cap) & ctrl[2];
        end
    end

    always_comb begin
        memreaddata = 32'h0;
        if (hit)
            case (sel)
                3'd0:    memreaddata = {29'h0, ctrl};
                3'd1:    memreaddata = count;
                3'd2:    memreaddata = compare;
                3'd3:    memreaddata = {30'h0, cap, match};
                3'd4:    memreaddata = 32'(prescale);
                3'd5:    memreaddata = capture;
                default: memreaddata = 32'h0;
            endcase
    end
endmodule
